// File: rtl/i2c_slave_regs_if.sv
// Pin-side and host-side signal bundle for i2c_slave_regs.
// The slave modport is the responder's view; master is the driver/bench view.
interface i2c_slave_regs_if #(
  parameter int ADDR_W = 4
) ();
  logic              scl_in;
  logic              sda_in;
  logic              sda_oe;
  logic [ADDR_W-1:0] host_addr;
  logic [7:0]        host_rdata;
  logic              wr_strobe;
  logic [ADDR_W-1:0] wr_addr;
  logic [7:0]        wr_data;
  logic              busy;

  modport slave (
    input  scl_in, sda_in, host_addr,
    output sda_oe, host_rdata, wr_strobe, wr_addr, wr_data, busy
  );

  modport master (
    output scl_in, sda_in, host_addr,
    input  sda_oe, host_rdata, wr_strobe, wr_addr, wr_data, busy
  );
endinterface

// File: rtl/i2c_slave_regs.sv
// I2C responder with a 2^ADDR_W byte register bank (7-bit address, 8-bit word address).
// Define I2C_SLAVE_GLITCH_FILTER_EN to add a 3-sample majority filter on SCL/SDA.
module i2c_slave_regs #(
  parameter logic [6:0] SLAVE_ADDR = 7'h51,
  parameter int         ADDR_W     = 4
) (
  input  logic            sys_clk,
  input  logic            sys_rst,
  i2c_slave_regs_if.slave bus
);

  localparam int DEPTH = 1 << ADDR_W;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_DEV_ADDR  = 4'd1;
  localparam logic [3:0] ST_ACK_ADDR  = 4'd2;
  localparam logic [3:0] ST_WORD_ADDR = 4'd3;
  localparam logic [3:0] ST_ACK_WORD  = 4'd4;
  localparam logic [3:0] ST_WR_DATA   = 4'd5;
  localparam logic [3:0] ST_ACK_DATA  = 4'd6;
  localparam logic [3:0] ST_RD_DATA   = 4'd7;
  localparam logic [3:0] ST_WAIT_MACK = 4'd8;
  localparam logic [3:0] ST_IGNORE    = 4'd9;

  // Channel 0 is SCL, channel 1 is SDA.
  logic [1:0] pin_raw;
  logic [1:0] pin_cond;
  assign pin_raw = {bus.sda_in, bus.scl_in};

  for (genvar gi = 0; gi < 2; gi++) begin : g_cond
    logic [1:0] sync_reg;

    // Idle bus is high; resetting to 1 avoids a phantom edge after reset.
    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        sync_reg <= 2'b11;
      end else begin
        sync_reg <= {sync_reg[0], pin_raw[gi]};
      end
    end

`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    logic [2:0] hist_reg;
    logic       filt_reg;

    always_ff @(posedge sys_clk) begin
      if (sys_rst) begin
        hist_reg <= 3'b111;
        filt_reg <= 1'b1;
      end else begin
        hist_reg <= {hist_reg[1:0], sync_reg[1]};
        filt_reg <= (hist_reg[0] & hist_reg[1]) |
                    (hist_reg[0] & hist_reg[2]) |
                    (hist_reg[1] & hist_reg[2]);
      end
    end

    assign pin_cond[gi] = filt_reg;
`else
    assign pin_cond[gi] = sync_reg[1];
`endif
  end

  logic scl_c;
  logic sda_c;
  assign scl_c = pin_cond[0];
  assign sda_c = pin_cond[1];

  logic scl_prev_reg;
  logic sda_prev_reg;
  logic scl_rise_reg;
  logic scl_fall_reg;
  logic start_reg;
  logic stop_reg;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      scl_prev_reg <= 1'b1;
      sda_prev_reg <= 1'b1;
      scl_rise_reg <= 1'b0;
      scl_fall_reg <= 1'b0;
      start_reg    <= 1'b0;
      stop_reg     <= 1'b0;
    end else begin
      scl_prev_reg <= scl_c;
      sda_prev_reg <= sda_c;
      scl_rise_reg <= scl_c & ~scl_prev_reg;
      scl_fall_reg <= ~scl_c & scl_prev_reg;
      start_reg    <= scl_c & scl_prev_reg & sda_prev_reg & ~sda_c;
      stop_reg     <= scl_c & scl_prev_reg & ~sda_prev_reg & sda_c;
    end
  end

  logic [3:0]        state_reg;
  logic [2:0]        bit_cnt_reg;
  logic [6:0]        rx_reg;
  logic [7:0]        tx_reg;
  logic [ADDR_W-1:0] ptr_reg;
  logic              rw_reg;
  logic              sda_oe_reg;
  logic              busy_reg;
  logic              wr_strobe_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [7:0]        wr_data_reg;
  logic [7:0]        rd_byte_reg;
  logic [7:0]        host_rdata_reg;
  logic [7:0]        bank_reg [DEPTH];

  // sda_prev_reg holds the SDA level that accompanied the detected SCL rise.
  logic [7:0] rx_byte;
  logic       last_bit;
  assign rx_byte  = {rx_reg, sda_prev_reg};
  assign last_bit = (bit_cnt_reg == 3'd7);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state_reg     <= ST_IDLE;
      bit_cnt_reg   <= 3'd0;
      rx_reg        <= 7'd0;
      tx_reg        <= 8'd0;
      ptr_reg       <= '0;
      rw_reg        <= 1'b0;
      sda_oe_reg    <= 1'b0;
      busy_reg      <= 1'b0;
      wr_strobe_reg <= 1'b0;
      wr_addr_reg   <= '0;
      wr_data_reg   <= 8'd0;
    end else begin
      wr_strobe_reg <= 1'b0;
      if (stop_reg) begin
        state_reg  <= ST_IDLE;
        sda_oe_reg <= 1'b0;
        busy_reg   <= 1'b0;
      end else if (start_reg) begin
        state_reg   <= ST_DEV_ADDR;
        bit_cnt_reg <= 3'd0;
        sda_oe_reg  <= 1'b0;
      end else begin
        case (state_reg)
          ST_DEV_ADDR: begin
            if (scl_rise_reg) begin
              rx_reg      <= rx_byte[6:0];
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (last_bit) begin
                if (rx_byte[7:1] == SLAVE_ADDR) begin
                  state_reg <= ST_ACK_ADDR;
                  busy_reg  <= 1'b1;
                  rw_reg    <= rx_byte[0];
                end else begin
                  state_reg <= ST_IGNORE;
                  busy_reg  <= 1'b0;
                end
              end
            end
          end

          // ACK is driven from the 8th falling edge through the 9th falling edge.
          ST_ACK_ADDR, ST_ACK_WORD, ST_ACK_DATA: begin
            if (scl_fall_reg) begin
              sda_oe_reg <= 1'b1;
            end
            if (scl_rise_reg) begin
              bit_cnt_reg <= 3'd0;
              if (state_reg == ST_ACK_ADDR) begin
                state_reg <= rw_reg ? ST_RD_DATA : ST_WORD_ADDR;
              end else if (state_reg == ST_ACK_WORD) begin
                state_reg <= ST_WR_DATA;
              end else begin
                ptr_reg   <= ptr_reg + ADDR_W'(1);
                state_reg <= ST_WR_DATA;
              end
            end
          end

          ST_WORD_ADDR, ST_WR_DATA: begin
            if (scl_fall_reg) begin
              sda_oe_reg <= 1'b0;
            end
            if (scl_rise_reg) begin
              rx_reg      <= rx_byte[6:0];
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (last_bit) begin
                if (state_reg == ST_WORD_ADDR) begin
                  ptr_reg   <= rx_byte[ADDR_W-1:0];
                  state_reg <= ST_ACK_WORD;
                end else begin
                  wr_strobe_reg <= 1'b1;
                  wr_addr_reg   <= ptr_reg;
                  wr_data_reg   <= rx_byte;
                  state_reg     <= ST_ACK_DATA;
                end
              end
            end
          end

          // First falling edge in the state loads the byte and drives its MSB.
          ST_RD_DATA: begin
            if (scl_fall_reg) begin
              if (bit_cnt_reg == 3'd0) begin
                tx_reg     <= {rd_byte_reg[6:0], 1'b0};
                sda_oe_reg <= ~rd_byte_reg[7];
              end else begin
                tx_reg     <= {tx_reg[6:0], 1'b0};
                sda_oe_reg <= ~tx_reg[7];
              end
            end
            if (scl_rise_reg) begin
              bit_cnt_reg <= bit_cnt_reg + 3'd1;
              if (last_bit) begin
                state_reg <= ST_WAIT_MACK;
              end
            end
          end

          ST_WAIT_MACK: begin
            if (scl_fall_reg) begin
              sda_oe_reg <= 1'b0;
            end
            if (scl_rise_reg) begin
              if (sda_prev_reg) begin
                state_reg <= ST_IGNORE;
                busy_reg  <= 1'b0;
              end else begin
                ptr_reg     <= ptr_reg + ADDR_W'(1);
                bit_cnt_reg <= 3'd0;
                state_reg   <= ST_RD_DATA;
              end
            end
          end

          default: begin
          end
        endcase
      end
    end
  end

  // Bank writes land on the edge that ends the wr_strobe cycle, so a host read
  // of the same address during the strobe returns the old byte.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        bank_reg[i] <= 8'h00;
      end
    end else if (wr_strobe_reg) begin
      bank_reg[wr_addr_reg] <= wr_data_reg;
    end
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      rd_byte_reg    <= 8'h00;
      host_rdata_reg <= 8'h00;
    end else begin
      rd_byte_reg    <= bank_reg[ptr_reg];
      host_rdata_reg <= bank_reg[bus.host_addr];
    end
  end

  assign bus.sda_oe     = sda_oe_reg;
  assign bus.busy       = busy_reg;
  assign bus.wr_strobe  = wr_strobe_reg;
  assign bus.wr_addr    = wr_addr_reg;
  assign bus.wr_data    = wr_data_reg;
  assign bus.host_rdata = host_rdata_reg;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: bit-banged I2C master, write scoreboard,
// host-port readback. Glitch expectation follows I2C_SLAVE_GLITCH_FILTER_EN.
module tb_i2c_slave_regs;
  localparam int ADDR_W = 4;
  localparam int Q      = 8;

  logic clk     = 1'b0;
  logic rst     = 1'b1;
  logic sda_drv = 1'b1;

  i2c_slave_regs_if #(.ADDR_W(ADDR_W)) bus ();
  assign bus.sda_in = sda_drv & ~bus.sda_oe;

  i2c_slave_regs #(.SLAVE_ADDR(7'h51), .ADDR_W(ADDR_W)) dut (
    .sys_clk (clk),
    .sys_rst (rst),
    .bus     (bus.slave)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  typedef struct packed {
    logic [3:0] addr;
    logic [7:0] data;
  } wr_t;

  wr_t  exp_q[$];
  bit   sb_off     = 1'b0;
  int   strobe_cnt = 0;
  bit   oe_seen    = 1'b0;
  bit   busy_seen  = 1'b0;
  logic last_oe    = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (bus.sda_oe) oe_seen = 1'b1;
    if (bus.busy) busy_seen = 1'b1;
    if (!rst && bus.wr_strobe) begin
      strobe_cnt++;
      if (!sb_off) begin
        check("sb_pending", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          wr_t e;
          e = exp_q.pop_front();
          check("wr_addr", 32'(bus.wr_addr), 32'(e.addr));
          check("wr_data", 32'(bus.wr_data), 32'(e.data));
          $display("write strobe addr=%0h data=%02h", bus.wr_addr, bus.wr_data);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic i2c_start;
    sda_drv = 1'b1; tick(Q);
    bus.scl_in = 1'b1; tick(Q);
    sda_drv = 1'b0; tick(Q);
    bus.scl_in = 1'b0; tick(Q);
  endtask

  task automatic i2c_stop;
    sda_drv = 1'b0; tick(Q);
    bus.scl_in = 1'b1; tick(Q);
    sda_drv = 1'b1; tick(Q);
  endtask

  task automatic send_bit(input logic b, input bit glitch);
    sda_drv = b;
    if (glitch) begin
      tick(3);
      bus.scl_in = 1'b1; tick(1);
      bus.scl_in = 1'b0; tick(Q - 4);
    end else begin
      tick(Q);
    end
    bus.scl_in = 1'b1; tick(Q);
    last_oe = bus.sda_oe; tick(Q);
    bus.scl_in = 1'b0; tick(Q);
  endtask

  task automatic recv_bit(output logic b);
    sda_drv = 1'b1; tick(Q);
    bus.scl_in = 1'b1; tick(Q);
    b = bus.sda_in; tick(Q);
    bus.scl_in = 1'b0; tick(Q);
  endtask

  task automatic write_byte(input logic [7:0] d, input bit glitch, output logic ack);
    for (int i = 7; i >= 0; i--) send_bit(d[i], glitch && (i == 7));
    recv_bit(ack);
    $display("master wrote %02h ack=%0b", d, ack);
  endtask

  task automatic read_byte(output logic [7:0] d, input logic mack);
    logic b;
    for (int i = 7; i >= 0; i--) begin
      recv_bit(b);
      d[i] = b;
    end
    send_bit(mack, 1'b0);
    $display("master read %02h mack=%0b", d, mack);
  endtask

  task automatic host_read(input logic [3:0] a, input logic [7:0] e, input string tag);
    bus.host_addr = a;
    tick(1);
    check(tag, 32'(bus.host_rdata), 32'(e));
    $display("host read addr=%0h data=%02h", a, bus.host_rdata);
  endtask

  task automatic do_write(input logic [3:0] a, input int n, input logic [7:0] b0,
                          input logic [7:0] b1, input logic [7:0] b2);
    logic       ack;
    logic [7:0] bytes [3];
    bytes[0] = b0; bytes[1] = b1; bytes[2] = b2;
    i2c_start;
    write_byte(8'hA2, 1'b0, ack); check("ack_dev", 32'(ack), 32'd0);
    write_byte({4'h0, a}, 1'b0, ack); check("ack_word", 32'(ack), 32'd0);
    for (int k = 0; k < n; k++) begin
      exp_q.push_back('{addr: a + 4'(k), data: bytes[k]});
      write_byte(bytes[k], 1'b0, ack); check("ack_data", 32'(ack), 32'd0);
    end
    i2c_stop;
    tick(Q);
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    check("busy_after_stop", 32'(bus.busy), 32'd0);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         s0;

    bus.scl_in    = 1'b1;
    bus.host_addr = '0;
    tick(5);
    check("rst_sda_oe", 32'(bus.sda_oe), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_wr_strobe", 32'(bus.wr_strobe), 32'd0);
    check("rst_wr_addr", 32'(bus.wr_addr), 32'd0);
    check("rst_wr_data", 32'(bus.wr_data), 32'd0);
    check("rst_host_rdata", 32'(bus.host_rdata), 32'd0);
    rst = 1'b0;
    tick(Q);

    // Single write, then readback
    do_write(4'h5, 1, 8'h3C, 8'h00, 8'h00);
    host_read(4'h5, 8'h3C, "host_rd_5");

    // Wrap-around burst
    do_write(4'hF, 3, 8'h11, 8'h22, 8'h33);
    host_read(4'hF, 8'h11, "host_rd_F");
    host_read(4'h0, 8'h22, "host_rd_0");
    host_read(4'h1, 8'h33, "host_rd_1");

    // Random read of bank[5] with repeated START
    i2c_start;
    write_byte(8'hA2, 1'b0, ack); check("rd_ack_dev_w", 32'(ack), 32'd0);
    write_byte(8'h05, 1'b0, ack); check("rd_ack_word", 32'(ack), 32'd0);
    i2c_start;
    write_byte(8'hA3, 1'b0, ack); check("rd_ack_dev_r", 32'(ack), 32'd0);
    check("rd_busy", 32'(bus.busy), 32'd1);
    read_byte(d, 1'b1);
    check("rd_data", 32'(d), 32'h3C);
    check("rd_nack_released", 32'(last_oe), 32'd0);
    i2c_stop;
    tick(Q);
    check("rd_busy_after_stop", 32'(bus.busy), 32'd0);

    // Wrong device address
    oe_seen = 1'b0; busy_seen = 1'b0; s0 = strobe_cnt;
    i2c_start;
    write_byte(8'hA0, 1'b0, ack); check("wa_nack", 32'(ack), 32'd1);
    write_byte(8'h01, 1'b0, ack);
    write_byte(8'h55, 1'b0, ack);
    i2c_stop;
    tick(Q);
    check("wa_oe_never", 32'(oe_seen), 32'd0);
    check("wa_busy_never", 32'(busy_seen), 32'd0);
    check("wa_no_strobe", 32'(strobe_cnt - s0), 32'd0);

    // One-cycle SCL glitch in the low phase before the first data bit
    sb_off = 1'b1;
    i2c_start;
    write_byte(8'hA2, 1'b0, ack);
    write_byte(8'h09, 1'b0, ack);
    write_byte(8'hA5, 1'b1, ack);
    i2c_stop;
    tick(Q);
    sb_off = 1'b0;
`ifdef I2C_SLAVE_GLITCH_FILTER_EN
    host_read(4'h9, 8'hA5, "glitch_filtered");
`else
    host_read(4'h9, 8'hD2, "glitch_misaligned");
`endif

    // Reset while bit 3 of a 0x00 read byte is driven low
    i2c_start;
    write_byte(8'hA2, 1'b0, ack); check("rr_ack_dev_w", 32'(ack), 32'd0);
    write_byte(8'h07, 1'b0, ack); check("rr_ack_word", 32'(ack), 32'd0);
    i2c_start;
    write_byte(8'hA3, 1'b0, ack); check("rr_ack_dev_r", 32'(ack), 32'd0);
    for (int i = 0; i < 4; i++) recv_bit(ack);
    sda_drv = 1'b1; tick(Q);
    bus.scl_in = 1'b1; tick(Q / 2);
    check("rr_bit3_driven", 32'(bus.sda_oe), 32'd1);
    rst = 1'b1;
    tick(1);
    check("rr_oe_released", 32'(bus.sda_oe), 32'd0);
    tick(1);
    rst = 1'b0;
    check("rr_busy", 32'(bus.busy), 32'd0);
    for (int a = 0; a < 16; a++) host_read(4'(a), 8'h00, "rr_bank_clear");
    bus.scl_in = 1'b0; tick(Q);
    i2c_stop;
    tick(Q);
    do_write(4'h3, 1, 8'h77, 8'h00, 8'h00);
    host_read(4'h3, 8'h77, "post_rst_rd_3");

    check("sb_final_empty", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
